// File: rtl/highmapper_pkg.sv
// Shared types and limits for the highmapper_n address router.
package highmapper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
  localparam int unsigned MAX_NCH      = 8;

endpackage

// File: rtl/highmapper_decode.sv
// Combinational base/mask region matcher; lowest-index hit wins.
module highmapper_decode #(
  parameter int unsigned       NCH      = 4,
  parameter logic [NCH*32-1:0] BASE_VEC = '0,
  parameter logic [NCH*32-1:0] MASK_VEC = '0
) (
  input  logic [31:0]    a,
  output logic [NCH-1:0] hit,
  output logic           unmapped
);

  // Priority scan: the first matching region claims the address.
  always_comb begin
    hit      = '0;
    unmapped = 1'b1;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (unmapped &&
          ((a & MASK_VEC[32*i +: 32]) == (BASE_VEC[32*i +: 32] & MASK_VEC[32*i +: 32]))) begin
        hit[i]   = 1'b1;
        unmapped = 1'b0;
      end
    end
  end

endmodule

// File: rtl/highmapper_n.sv
// Registered address router: one master to NCH slave channels via a
// base/mask region table. Unmapped accesses end with a bus error.
// Optional HIGHMAPPER_TIMEOUT_EN aborts hung slave accesses after TIMEOUT_CYC.
module highmapper_n
  import highmapper_pkg::*;
#(
  parameter int unsigned       NCH         = 4,
  parameter logic [NCH*32-1:0] BASE_VEC    = {32'h3000_0000, 32'h2000_0000,
                                              32'h1000_0000, 32'h0000_0000},
  parameter logic [NCH*32-1:0] MASK_VEC    = {4{32'hF000_0000}},
  parameter logic [31:0]       ERR_DATA    = ERR_DATA_DEF,
  parameter int unsigned       TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       a,
  input  logic [31:0]       d,
  input  logic              we,
  input  logic              rd,
  output logic [31:0]       spo,
  output logic              ready,
  output logic              err,
  output logic [NCH*32-1:0] s_a,
  output logic [NCH*32-1:0] s_d,
  output logic [NCH-1:0]    s_we,
  output logic [NCH-1:0]    s_rd,
  input  logic [NCH*32-1:0] s_spo,
  input  logic [NCH-1:0]    s_ready
);

  if (NCH < 1 || NCH > MAX_NCH || TIMEOUT_CYC < 2) begin : g_bad_params
    $error("highmapper_n: illegal NCH or TIMEOUT_CYC");
  end

  state_t          state, next_state;
  logic [31:0]     a_q, d_q;
  logic            we_q, rd_q;
  logic [NCH-1:0]  sel_q;
  logic [NCH-1:0]  hit;
  logic            unmapped;
  logic            req;
  logic            sel_ready;
  logic [31:0]     sel_spo;
  logic            tmo_hit;

  highmapper_decode #(
    .NCH      (NCH),
    .BASE_VEC (BASE_VEC),
    .MASK_VEC (MASK_VEC)
  ) u_decode (
    .a        (a),
    .hit      (hit),
    .unmapped (unmapped)
  );

  assign req = rd | we;

`ifdef HIGHMAPPER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] tmo_cnt;

  // Wait counter: zero outside REQ, so it is clear on every REQ entry.
  always_ff @(posedge clk) begin
    if (rst || state != REQ) tmo_cnt <= '0;
    else                     tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Select the latched channel's ready and read data.
  always_comb begin
    sel_ready = 1'b0;
    sel_spo   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (sel_q[i]) begin
        sel_ready = s_ready[i];
        sel_spo   = s_spo[32*i +: 32];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; slave ready beats a same-cycle timeout.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = unmapped ? DONE : REQ;
      REQ:     if (sel_ready || tmo_hit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latch and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      d_q   <= '0;
      we_q  <= 1'b0;
      rd_q  <= 1'b0;
      sel_q <= '0;
      spo   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            a_q   <= a;
            d_q   <= d;
            we_q  <= we;
            rd_q  <= rd & ~we;
            sel_q <= hit;
            if (unmapped) begin
              spo <= ERR_DATA;
              err <= 1'b1;
            end
          end
        end
        REQ: begin
          if (sel_ready) begin
            spo <= rd_q ? sel_spo : '0;
            err <= 1'b0;
          end else if (tmo_hit) begin
            spo <= ERR_DATA;
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Slave-side outputs are pure decodes of registered state.
  always_comb begin
    ready = (state == DONE);
    s_we  = (state == REQ) ? (sel_q & {NCH{we_q}}) : '0;
    s_rd  = (state == REQ) ? (sel_q & {NCH{rd_q}}) : '0;
    s_a   = {NCH{a_q}};
    s_d   = {NCH{d_q}};
  end

endmodule

// File: tb/tb_highmapper_n.sv
// Directed self-checking bench for highmapper_n.
module tb_highmapper_n;

  localparam int unsigned NCH = 4;

  logic              clk;
  logic              rst;
  logic [31:0]       a, d;
  logic              we, rd;
  logic [31:0]       spo;
  logic              ready, err;
  logic [NCH*32-1:0] s_a, s_d;
  logic [NCH-1:0]    s_we, s_rd;
  logic [NCH*32-1:0] s_spo;
  logic [NCH-1:0]    s_ready;

  int checks = 0;
  int errors = 0;

  highmapper_n #(
    .NCH         (NCH),
    .BASE_VEC    ({32'h1000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .MASK_VEC    ({32'hFF00_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000}),
    .ERR_DATA    (32'hDEAD_BEEF),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .d       (d),
    .we      (we),
    .rd      (rd),
    .spo     (spo),
    .ready   (ready),
    .err     (err),
    .s_a     (s_a),
    .s_d     (s_d),
    .s_we    (s_we),
    .s_rd    (s_rd),
    .s_spo   (s_spo),
    .s_ready (s_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst     = 1'b1;
    a       = '0;
    d       = '0;
    we      = 1'b0;
    rd      = 1'b0;
    s_spo   = '0;
    s_ready = '0;
    tick();
    tick();
    chk("rst_ready", 128'(ready), 128'(1'b0));
    chk("rst_err",   128'(err),   128'(1'b0));
    chk("rst_spo",   128'(spo),   128'(32'h0));
    chk("rst_s_we",  128'(s_we),  128'(4'b0000));
    chk("rst_s_rd",  128'(s_rd),  128'(4'b0000));
    chk("rst_s_a",   128'(s_a),   128'(0));
    rst = 1'b0;
    tick();

    // Read ch0, slave always ready: strobe one cycle, ready two cycles later.
    s_ready           = 4'b0001;
    s_spo[31:0]       = 32'h1234_5678;
    s_spo[127:96]     = 32'h3333_3333;
    a                 = 32'h0000_0010;
    rd                = 1'b1;
    tick();
    chk("rd0_req_s_rd",  128'(s_rd),        128'(4'b0001));
    chk("rd0_req_s_a0",  128'(s_a[31:0]),   128'(32'h0000_0010));
    chk("rd0_req_s_a3",  128'(s_a[127:96]), 128'(32'h0000_0010));
    chk("rd0_req_ready", 128'(ready),       128'(1'b0));
    tick();
    chk("rd0_done_ready", 128'(ready), 128'(1'b1));
    chk("rd0_done_err",   128'(err),   128'(1'b0));
    chk("rd0_done_spo",   128'(spo),   128'(32'h1234_5678));
    chk("rd0_done_s_rd",  128'(s_rd),  128'(4'b0000));
    rd = 1'b0;
    tick();
    chk("rd0_idle_ready", 128'(ready), 128'(1'b0));
    chk("rd0_idle_spo",   128'(spo),   128'(32'h1234_5678));

    // Write ch2 with three wait cycles; ch0 ready is high but unselected.
    a  = 32'h2000_0004;
    d  = 32'hA5A5_A5A5;
    we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) s_ready[2] = 1'b1;
      chk("wr2_s_we",  128'(s_we),       128'(4'b0100));
      chk("wr2_s_rd",  128'(s_rd),       128'(4'b0000));
      chk("wr2_s_d2",  128'(s_d[95:64]), 128'(32'hA5A5_A5A5));
      chk("wr2_ready", 128'(ready),      128'(1'b0));
    end
    tick();
    chk("wr2_done_ready", 128'(ready), 128'(1'b1));
    chk("wr2_done_err",   128'(err),   128'(1'b0));
    chk("wr2_done_spo",   128'(spo),   128'(32'h0));
    chk("wr2_done_s_we",  128'(s_we),  128'(4'b0000));
    we         = 1'b0;
    s_ready[2] = 1'b0;
    tick();

    // Unmapped read: error on the next cycle, no slave strobe.
    a  = 32'h8000_0000;
    rd = 1'b1;
    tick();
    chk("unm_ready", 128'(ready), 128'(1'b1));
    chk("unm_err",   128'(err),   128'(1'b1));
    chk("unm_spo",   128'(spo),   128'(32'hDEAD_BEEF));
    chk("unm_s_rd",  128'(s_rd),  128'(4'b0000));
    rd = 1'b0;
    tick();
    chk("unm_idle_ready", 128'(ready), 128'(1'b0));
    chk("unm_idle_err",   128'(err),   128'(1'b1));

    // Overlap: ch1 and ch3 both match 0x1000_0000, ch1 must win.
    s_ready        = 4'b1010;
    s_spo[63:32]   = 32'hCAFE_0001;
    a              = 32'h1000_0000;
    rd             = 1'b1;
    tick();
    chk("ovl_s_rd", 128'(s_rd), 128'(4'b0010));
    tick();
    chk("ovl_ready", 128'(ready), 128'(1'b1));
    chk("ovl_err",   128'(err),   128'(1'b0));
    chk("ovl_spo",   128'(spo),   128'(32'hCAFE_0001));
    rd = 1'b0;
    tick();

    // rd and we together behave as a write.
    s_ready = 4'b0001;
    a       = 32'h0000_0020;
    d       = 32'h0000_0001;
    rd      = 1'b1;
    we      = 1'b1;
    tick();
    chk("both_s_we", 128'(s_we), 128'(4'b0001));
    chk("both_s_rd", 128'(s_rd), 128'(4'b0000));
    tick();
    chk("both_ready", 128'(ready), 128'(1'b1));
    chk("both_spo",   128'(spo),   128'(32'h0));
    rd = 1'b0;
    we = 1'b0;
    tick();

    // Reset during REQ aborts silently; next read completes normally.
    s_ready = 4'b0000;
    a       = 32'h0000_0030;
    rd      = 1'b1;
    tick();
    chk("rstreq_s_rd", 128'(s_rd), 128'(4'b0001));
    rst = 1'b1;
    tick();
    chk("rstreq_s_rd_after", 128'(s_rd),      128'(4'b0000));
    chk("rstreq_ready",      128'(ready),     128'(1'b0));
    chk("rstreq_s_a0",       128'(s_a[31:0]), 128'(32'h0));
    rst = 1'b0;
    rd  = 1'b0;
    tick();
    chk("rstreq_idle_ready", 128'(ready), 128'(1'b0));
    s_ready = 4'b0001;
    a       = 32'h0000_0040;
    rd      = 1'b1;
    tick();
    chk("rstreq_next_s_rd", 128'(s_rd), 128'(4'b0001));
    tick();
    chk("rstreq_next_ready", 128'(ready), 128'(1'b1));
    chk("rstreq_next_spo",   128'(spo),   128'(32'h1234_5678));
    rd = 1'b0;
    tick();

`ifdef HIGHMAPPER_TIMEOUT_EN
    // ch1 never ready: strobe for 8 cycles, then error; late ready ignored.
    s_ready = 4'b0000;
    a       = 32'h1000_0100;
    rd      = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("tmo_s_rd",  128'(s_rd),  128'(4'b0010));
      chk("tmo_ready", 128'(ready), 128'(1'b0));
    end
    tick();
    chk("tmo_done_ready", 128'(ready), 128'(1'b1));
    chk("tmo_done_err",   128'(err),   128'(1'b1));
    chk("tmo_done_spo",   128'(spo),   128'(32'hDEAD_BEEF));
    chk("tmo_done_s_rd",  128'(s_rd),  128'(4'b0000));
    rd = 1'b0;
    tick();
    s_ready[1] = 1'b1;
    tick();
    s_ready[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tmo_late_ready", 128'(ready), 128'(1'b0));
      chk("tmo_late_s_rd",  128'(s_rd),  128'(4'b0000));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/highmapper_n.md
# highmapper_n

Parametrised, registered address router between one bus master and `NCH` slave channels (memory, MMIO, ROM, ...). It sits directly behind the CPU bridge and replaces the fixed two-way mem/MMIO split with a base/mask region table. The request is registered so decode is off the critical path. Unmapped addresses and, optionally, hung slaves terminate with a bus-error response instead of stalling the core.

## Interface
Parameters:
- `NCH`, 4: number of slave channels, 1..8.
- `BASE_VEC`, {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}: region base for channel i at bits [32i+31:32i].
- `MASK_VEC`, {4{32'hF000_0000}}: match mask for channel i; hit when `(a & mask) == (base & mask)`.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on error.
- `TIMEOUT_CYC`, 1024: slave wait limit in cycles, ≥2. Used only with `HIGHMAPPER_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `a` in 32: master address.
- `d` in 32: master write data.
- `we` in 1: write request.
- `rd` in 1: read request.
- `spo` out 32: read data (registered).
- `ready` out 1: one-cycle completion pulse.
- `err` out 1: qualifies `ready`; high means the access faulted.
- `s_a` out NCH*32: per-channel address.
- `s_d` out NCH*32: per-channel write data.
- `s_we` out NCH: per-channel write strobe.
- `s_rd` out NCH: per-channel read strobe.
- `s_spo` in NCH*32: per-channel read data.
- `s_ready` in NCH: per-channel ready.

## Operation
- Master protocol: assert exactly one of `rd`/`we`, with `a`/`d` stable, until `ready` is seen. Drop the strobe the cycle after `ready`.
- Decode: lowest-index hitting channel wins. No hit means unmapped.
- FSM states: IDLE, REQ, DONE.
- IDLE: on `rd|we`, latch `a`, `d`, `we`, `rd`, the one-hot select, and an unmapped flag.
  - If mapped, go to REQ.
  - If unmapped, go to DONE with `err`=1 and `spo`=`ERR_DATA`. Writes are dropped.
- REQ: the selected channel's `s_we`/`s_rd` equal the latched strobes; all other strobes are 0.
  - `s_a`/`s_d` of every channel carry the latched `a`/`d`.
  - When the selected channel's `s_ready`=1: capture its `s_spo` into `spo` (reads only; writes capture 0), set `err`=0, go to DONE.
  - `s_ready` of unselected channels is ignored.
- DONE: `ready`=1 for exactly one cycle, then go to IDLE. A request present in that IDLE cycle starts a new transaction.
- `rd` and `we` both high in IDLE: treat as a write, `rd` ignored.
- Outputs outside DONE: `ready`=0. `spo` and `err` hold their last value.

## Timing
- Reset values: state=IDLE, `ready`=0, `err`=0, `spo`=0, all `s_we`/`s_rd`=0. Latched `a`/`d`, and therefore `s_a`/`s_d`, reset to 0.
- Minimum latency: request in IDLE cycle N, slave strobe in cycle N+1, `ready` in cycle N+2 if the slave is ready in N+1.
- General latency: 2 + W cycles, where W is the number of REQ cycles with `s_ready` low.
- Unmapped access: `ready` in cycle N+1.
- Reset mid-transaction: next edge forces IDLE and deasserts strobes. No `ready` is issued for the aborted access.
- Slave strobes are registered state decodes: no combinational path from `a`/`rd`/`we` to `s_*`.

## Configuration
- `HIGHMAPPER_TIMEOUT_EN` defined:
  - A counter clears on entry to REQ and increments each REQ cycle.
  - When the counter reaches `TIMEOUT_CYC`-1 with `s_ready` still low, drop the strobes and go to DONE with `err`=1 and `spo`=`ERR_DATA`.
  - Slave ready in that same cycle takes priority: it is a normal completion.
  - A late `s_ready` after abort is ignored.
- Undefined: no counter; REQ waits indefinitely. Unmapped error still applies.

## Structure
- `highmapper_pkg` holds:
  - the state enum (IDLE/REQ/DONE);
  - the default `ERR_DATA` constant;
  - the `MAX_NCH`=8 limit.
- Sub-module `highmapper_decode`: combinational priority matcher taking `a`, `BASE_VEC` and `MASK_VEC`, producing a one-hot hit vector and an unmapped flag.

## Test plan
- Read 0x0000_0010; ch0 `s_ready` tied 1 returning 0x1234_5678 → `s_rd[0]` high for 1 cycle; `ready` 2 cycles after request with `spo`=0x1234_5678, `err`=0.
- Write 0x2000_0004, d=0xA5A5_A5A5; ch2 holds ready low 3 cycles → `s_we[2]` high 4 cycles with `s_d[2]`=0xA5A5_A5A5; `ready` at cycle 6; no other channel strobed.
- Read 0x8000_0000 (no region) → `ready` the next cycle, `err`=1, `spo`=0xDEAD_BEEF; no `s_rd` bits set.
- Overlapping regions (ch1 base 0x1000_0000, mask 0xF000_0000; ch3 base 0x1000_0000, mask 0xFF00_0000), read 0x1000_0000 → ch1 selected.
- `HIGHMAPPER_TIMEOUT_EN`, `TIMEOUT_CYC`=8, ch1 never ready → strobe high 8 cycles, then `ready` with `err`=1; a later `s_ready[1]` pulse causes no response.
- Assert `rst` during REQ → strobes low after the edge, no `ready`; the next read completes normally.
